// File: rtl/ptr_ecc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ptr_ecc_pkg                                                       |
// | Widths, codeword bit map and Hamming(14,10) helpers.              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package ptr_ecc_pkg;

    localparam int ENC_W = 14;
    localparam int DAT_W = 10;
    localparam logic [3:0] SYN_UNCORR = 4'd15;

    // Codeword position of data bit i sits in nibble i (d0 in the low nibble).
    localparam logic [4*DAT_W-1:0] DATA_POS = {4'd13, 4'd12, 4'd11, 4'd10, 4'd9,
                                               4'd8,  4'd6,  4'd5,  4'd4,  4'd2};

    function automatic logic [3:0] hamming_syn(input logic [ENC_W-1:0] e);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < ENC_W; j++) begin
                if ((((j + 1) >> k) & 1) == 1) begin
                    s[2'(k)] = s[2'(k)] ^ e[4'(j)];
                end
            end
        end
        return s;
    endfunction

    function automatic logic [DAT_W-1:0] hamming_data(input logic [ENC_W-1:0] e);
        logic [DAT_W-1:0] d;
        d = '0;
        for (int i = 0; i < DAT_W; i++) begin
            d[4'(i)] = e[DATA_POS[4*i +: 4]];
        end
        return d;
    endfunction

    // Each parity bit is the only parity position in its own group, so the
    // syndrome of a word with zeroed parity bits is exactly the parity needed.
    function automatic logic [ENC_W-1:0] hamming_enc(input logic [DAT_W-1:0] d);
        logic [ENC_W-1:0] e;
        logic [3:0]       s;
        e = '0;
        for (int i = 0; i < DAT_W; i++) begin
            e[DATA_POS[4*i +: 4]] = d[4'(i)];
        end
        s    = hamming_syn(e);
        e[0] = s[0];
        e[1] = s[1];
        e[3] = s[2];
        e[7] = s[3];
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ptr_decode                                                        |
// | 14-bit SEC codeword to corrected 10-bit pointer plus syndrome.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ptr_decode
    import ptr_ecc_pkg::*;
(
    input  logic [ENC_W-1:0] enc,
    output logic [DAT_W-1:0] dat,
    output logic [3:0]       syn
);

    logic [ENC_W-1:0] fixed;

    always_comb begin
        syn   = hamming_syn(enc);
        fixed = enc;
        // Syndrome 15 has no matching position: pass the raw data through.
        if (syn != 4'd0 && syn != SYN_UNCORR) begin
            fixed[syn - 4'd1] = ~enc[syn - 4'd1];
        end
        dat = hamming_data(fixed);
    end

endmodule
`default_nettype wire

// File: rtl/ptr_encode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ptr_encode                                                        |
// | Combinational 10-bit pointer to 14-bit SEC codeword encoder.      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ptr_encode
    import ptr_ecc_pkg::*;
(
    input  logic [DAT_W-1:0] dat,
    output logic [ENC_W-1:0] enc
);

    assign enc = hamming_enc(dat);

endmodule
`default_nettype wire

// File: rtl/ptr_ecc_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ptr_ecc_counter                                                   |
// | Hamming-protected FIFO pointer with scrub, injection and status.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ptr_ecc_counter
    import ptr_ecc_pkg::*;
#(
    parameter int PTR_MAX  = 1023,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic             clr,
    input  logic             inj_en,
    input  logic [3:0]       inj_idx,
    output logic [ENC_W-1:0] enc_ptr,
    output logic [DAT_W-1:0] ptr_bin,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [7:0]       err_cnt
);

    localparam logic [DAT_W-1:0] PTR_LAST = DAT_W'(PTR_MAX);

    logic [ENC_W-1:0] enc_q, enc_d;
    logic             err_corr_q, err_corr_d;
    logic             err_uncorr_q, err_uncorr_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [3:0]       syn;
    logic             syn_corr;
    logic             wr;
    logic [DAT_W-1:0] nxt;
    logic [ENC_W-1:0] nxt_enc;
    logic [ENC_W-1:0] inj_mask;

    ptr_decode u_dec (
        .enc (enc_q),
        .dat (ptr_bin),
        .syn (syn)
    );

    ptr_encode u_enc (
        .dat (nxt),
        .enc (nxt_enc)
    );

    always_comb begin
        syn_corr = (syn != 4'd0) && (syn != SYN_UNCORR);

        nxt = ptr_bin;
        if (clr) begin
            nxt = '0;
        end else if (inc_en) begin
            nxt = (ptr_bin == PTR_LAST) ? '0 : ptr_bin + 10'd1;
        end

        // Uncorrectable words are left alone unless clr/inc_en overwrite them.
        wr = clr || inc_en || (SCRUB_EN && syn_corr);

        inj_mask = '0;
        if (inj_en && inj_idx != 4'd0 && inj_idx != 4'd15) begin
            inj_mask[inj_idx - 4'd1] = 1'b1;
        end

        enc_d      = (wr ? nxt_enc : enc_q) ^ inj_mask;
        err_corr_d = syn_corr;

        // The syndrome describes the pre-clear word, so a set beats clr.
        err_uncorr_d = err_uncorr_q;
        if (syn == SYN_UNCORR) begin
            err_uncorr_d = 1'b1;
        end else if (clr) begin
            err_uncorr_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (syn_corr && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_q        <= '0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            enc_q        <= enc_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign enc_ptr    = enc_q;
    assign err_corr   = err_corr_q;
    assign err_uncorr = err_uncorr_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ptr_ecc_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ptr_ecc_counter                                                |
// | Scoreboard bench: scrubbing full-depth DUT and non-scrub depth-6. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ptr_ecc_counter;

    typedef struct {
        int         d;
        logic [13:0] enc;
        logic [9:0]  pb;
        logic        corr;
        logic        unc;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        inc_en [2];
    logic        clr    [2];
    logic        inj_en [2];
    logic [3:0]  inj_idx[2];
    logic [13:0] enc_ptr[2];
    logic [9:0]  ptr_bin[2];
    logic        err_corr[2];
    logic        err_uncorr[2];
    logic [7:0]  err_cnt[2];

    exp_t        exp_q[$];
    int          vectors;
    int          miscompares;

    logic [13:0] m_st  [2];
    logic        m_unc [2];
    logic        m_corr[2];
    logic [7:0]  m_cnt [2];
    logic [9:0]  pmax  [2] = '{10'd1023, 10'd5};
    bit          scr   [2] = '{1'b1, 1'b0};

    ptr_ecc_counter #(.PTR_MAX(1023), .SCRUB_EN(1'b1)) dut_scrub (
        .clk(clk), .rst_n(rst_n), .inc_en(inc_en[0]), .clr(clr[0]),
        .inj_en(inj_en[0]), .inj_idx(inj_idx[0]), .enc_ptr(enc_ptr[0]),
        .ptr_bin(ptr_bin[0]), .err_corr(err_corr[0]),
        .err_uncorr(err_uncorr[0]), .err_cnt(err_cnt[0])
    );

    ptr_ecc_counter #(.PTR_MAX(5), .SCRUB_EN(1'b0)) dut_noscrub (
        .clk(clk), .rst_n(rst_n), .inc_en(inc_en[1]), .clr(clr[1]),
        .inj_en(inj_en[1]), .inj_idx(inj_idx[1]), .enc_ptr(enc_ptr[1]),
        .ptr_bin(ptr_bin[1]), .err_corr(err_corr[1]),
        .err_uncorr(err_uncorr[1]), .err_cnt(err_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written directly from the parity-group equations.
    function automatic logic [13:0] m_encode(input logic [9:0] d);
        logic [13:0] e;
        e = '0;
        e[2] = d[0]; e[4] = d[1]; e[5] = d[2]; e[6] = d[3];
        e[13:8] = d[9:4];
        e[0] = e[2] ^ e[4] ^ e[6] ^ e[8] ^ e[10] ^ e[12];
        e[1] = e[2] ^ e[5] ^ e[6] ^ e[9] ^ e[10] ^ e[13];
        e[3] = e[4] ^ e[5] ^ e[6] ^ e[11] ^ e[12] ^ e[13];
        e[7] = ^e[13:8];
        return e;
    endfunction

    function automatic logic [3:0] m_syn(input logic [13:0] e);
        logic [3:0] s;
        s[0] = e[0] ^ e[2] ^ e[4] ^ e[6] ^ e[8] ^ e[10] ^ e[12];
        s[1] = e[1] ^ e[2] ^ e[5] ^ e[6] ^ e[9] ^ e[10] ^ e[13];
        s[2] = e[3] ^ e[4] ^ e[5] ^ e[6] ^ e[11] ^ e[12] ^ e[13];
        s[3] = ^e[13:7];
        return s;
    endfunction

    function automatic logic [9:0] m_decode(input logic [13:0] e);
        logic [3:0]  s;
        logic [13:0] f;
        s = m_syn(e);
        f = e;
        if (s >= 4'd1 && s <= 4'd14) f[s - 4'd1] = ~f[s - 4'd1];
        return {f[13:8], f[6], f[5], f[4], f[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit inc, input bit c, input bit inj,
                         input logic [3:0] idx);
        inc_en[d]  = inc;
        clr[d]     = c;
        inj_en[d]  = inj;
        inj_idx[d] = idx;
    endtask

    // Advance the model, queue expectations, clock the DUTs, then check.
    task automatic tick();
        logic [3:0]  s;
        logic [9:0]  pb;
        logic [9:0]  nx;
        logic [13:0] ne;
        logic        corr;
        bit          wr;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_st[d] = '0; m_unc[d] = 1'b0; m_corr[d] = 1'b0; m_cnt[d] = '0;
            end else begin
                s    = m_syn(m_st[d]);
                pb   = m_decode(m_st[d]);
                corr = (s >= 4'd1 && s <= 4'd14);
                if (clr[d])         nx = '0;
                else if (inc_en[d]) nx = (pb == pmax[d]) ? 10'd0 : pb + 10'd1;
                else                nx = pb;
                wr = clr[d] || inc_en[d] || (scr[d] && corr);
                ne = wr ? m_encode(nx) : m_st[d];
                if (inj_en[d] && inj_idx[d] >= 4'd1 && inj_idx[d] <= 4'd14)
                    ne[inj_idx[d] - 4'd1] = ~ne[inj_idx[d] - 4'd1];
                if (s == 4'd15)  m_unc[d] = 1'b1;
                else if (clr[d]) m_unc[d] = 1'b0;
                if (corr && m_cnt[d] != 8'd255) m_cnt[d] = m_cnt[d] + 8'd1;
                m_corr[d] = corr;
                m_st[d]   = ne;
            end
            e.d = d; e.enc = m_st[d]; e.pb = m_decode(m_st[d]);
            e.corr = m_corr[d]; e.unc = m_unc[d]; e.cnt = m_cnt[d];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("d%0d enc_ptr", e.d), 32'(enc_ptr[e.d]), 32'(e.enc));
                chk($sformatf("d%0d ptr_bin", e.d), 32'(ptr_bin[e.d]), 32'(e.pb));
                chk($sformatf("d%0d err_corr", e.d), 32'(err_corr[e.d]), 32'(e.corr));
                chk($sformatf("d%0d err_uncorr", e.d), 32'(err_uncorr[e.d]), 32'(e.unc));
                chk($sformatf("d%0d err_cnt", e.d), 32'(err_cnt[e.d]), 32'(e.cnt));
            end
        end
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 4'd0);
            m_st[d] = '0; m_unc[d] = 1'b0; m_corr[d] = 1'b0; m_cnt[d] = '0;
        end

        // Reset, with active inputs that reset must override
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b1, 4'd3);
        tick();
        tick();
        chk("reset enc_ptr", 32'(enc_ptr[0]), 32'h0000);
        chk("reset ptr_bin", 32'(ptr_bin[0]), 32'd0);
        chk("reset err_corr", 32'(err_corr[0]), 32'd0);
        chk("reset err_uncorr", 32'(err_uncorr[0]), 32'd0);
        chk("reset err_cnt", 32'(err_cnt[0]), 32'd0);
        rst_n = 1'b1;

        // Count up through the full range and wrap
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("inc1 enc_ptr", 32'(enc_ptr[0]), 32'h0007);
        chk("inc1 ptr_bin", 32'(ptr_bin[0]), 32'd1);
        repeat (1022) begin
            drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
            tick();
        end
        chk("max ptr_bin", 32'(ptr_bin[0]), 32'd1023);
        chk("max enc_ptr", 32'(enc_ptr[0]), 32'h3F74);
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("wrap ptr_bin", 32'(ptr_bin[0]), 32'd0);
        chk("wrap enc_ptr", 32'(enc_ptr[0]), 32'h0000);

        // Idle data-bit upset is corrected at once and scrubbed next edge
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b1, 4'd3);
        tick();
        chk("inj enc_ptr", 32'(enc_ptr[0]), 32'h0003);
        chk("inj ptr_bin", 32'(ptr_bin[0]), 32'd1);
        tick();
        chk("scrub enc_ptr", 32'(enc_ptr[0]), 32'h0007);
        chk("scrub err_corr", 32'(err_corr[0]), 32'd1);
        chk("scrub err_cnt", 32'(err_cnt[0]), 32'd1);
        tick();
        chk("scrub pulse end", 32'(err_corr[0]), 32'd0);

        // Increment on top of an upset uses the corrected pointer
        drive(0, 1'b0, 1'b0, 1'b1, 4'd5);
        tick();
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("inc-err ptr_bin", 32'(ptr_bin[0]), 32'd2);
        chk("inc-err enc_ptr", 32'(enc_ptr[0]), 32'h0019);
        chk("inc-err err_corr", 32'(err_corr[0]), 32'd1);
        tick();

        // Parity-bit upset: data unaffected
        drive(0, 1'b0, 1'b0, 1'b1, 4'd8);
        tick();
        chk("par-inj ptr_bin", 32'(ptr_bin[0]), 32'd2);
        tick();
        tick();

        // clr beats inc_en; inj_idx 15 injects nothing
        drive(0, 1'b1, 1'b1, 1'b1, 4'd15);
        tick();
        chk("clr+inc ptr_bin", 32'(ptr_bin[0]), 32'd0);
        chk("clr+inc enc_ptr", 32'(enc_ptr[0]), 32'h0000);

        // Non-scrub DUT: double error -> sticky uncorrectable
        drive(1, 1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        drive(1, 1'b0, 1'b0, 1'b1, 4'd14);
        tick();
        tick();
        chk("dbl err_uncorr", 32'(err_uncorr[1]), 32'd1);
        tick();
        tick();
        chk("dbl sticky", 32'(err_uncorr[1]), 32'd1);
        drive(1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        chk("clr enc_ptr", 32'(enc_ptr[1]), 32'h0000);
        chk("clr set-wins", 32'(err_uncorr[1]), 32'd1);
        drive(1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        chk("clr err_uncorr", 32'(err_uncorr[1]), 32'd0);
        chk("clr keeps cnt", 32'(err_cnt[1]), 32'd1);

        // Non-power-of-two wrap at PTR_MAX=5
        repeat (6) begin
            drive(1, 1'b1, 1'b0, 1'b0, 4'd0);
            tick();
        end
        chk("wrap5 ptr_bin", 32'(ptr_bin[1]), 32'd0);

        // Persistent error without scrub saturates the counter
        repeat (2) begin
            drive(1, 1'b1, 1'b0, 1'b0, 4'd0);
            tick();
        end
        drive(1, 1'b0, 1'b0, 1'b1, 4'd9);
        tick();
        repeat (300) tick();
        chk("sat err_cnt", 32'(err_cnt[1]), 32'd255);
        chk("sat ptr_bin", 32'(ptr_bin[1]), 32'd2);
        chk("sat err_corr", 32'(err_corr[1]), 32'd1);
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("sat inc ptr_bin", 32'(ptr_bin[1]), 32'd3);
        chk("sat inc enc_ptr", 32'(enc_ptr[1]), 32'h001E);
        tick();
        chk("sat clean corr", 32'(err_corr[1]), 32'd0);
        chk("sat hold cnt", 32'(err_cnt[1]), 32'd255);

        // Mid-run reset clears the saturated counter too
        rst_n = 1'b0;
        drive(1, 1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        rst_n = 1'b1;
        chk("rst2 err_cnt", 32'(err_cnt[1]), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
